// File: rtl/dc_wb_buffer_if.sv
// dc_wb_buffer_if: evict push, memory write beats and miss lookup bus; fwd_data exists only with WB_FWD_EN
interface dc_wb_buffer_if #(parameter int LINE_W = 128);
    logic              dc_evict;
    logic [31:0]       dc_evict_addr;
    logic [LINE_W-1:0] dc_evict_data;
    logic              wb_full;
    logic              wb_empty;
    logic              mem_wr_req;
    logic [31:0]       mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_wr_last;
    logic              mem_wr_ack;
    logic [31:0]       miss_addr;
    logic              miss_hit;
`ifdef WB_FWD_EN
    logic [LINE_W-1:0] fwd_data;
`endif
    modport master (
        output dc_evict, dc_evict_addr, dc_evict_data, mem_wr_ack, miss_addr,
        input  wb_full, wb_empty, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_last, miss_hit
`ifdef WB_FWD_EN
        , input fwd_data
`endif
    );
    modport slave (
        input  dc_evict, dc_evict_addr, dc_evict_data, mem_wr_ack, miss_addr,
        output wb_full, wb_empty, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_last, miss_hit
`ifdef WB_FWD_EN
        , output fwd_data
`endif
    );
endinterface

// File: rtl/dc_wb_buffer.sv
// dc_wb_buffer: dirty-line FIFO drained as 4x32-bit write bursts, with miss lookup; WB_FWD_EN adds line forwarding
module dc_wb_buffer #(
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1,
    parameter int LINE_W = 128
) (
    input logic          clk,
    input logic          rst,
    dc_wb_buffer_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_n;
    logic [1:0]        beat, beat_n;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [27:0]       addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic              push, pop;
    logic              unused_bits;

    assign unused_bits      = ^{bus.dc_evict_addr[3:0], bus.miss_addr[3:0]};
    assign bus.wb_full      = count == (PTR_W+1)'(DEPTH);
    assign bus.wb_empty     = count == '0 && state == IDLE;
    assign push             = bus.dc_evict && !bus.wb_full;
    assign pop              = state == SEND && bus.mem_wr_ack && beat == 2'd3;
    assign bus.mem_wr_req   = state == SEND;
    assign bus.mem_wr_last  = state == SEND && beat == 2'd3;
    assign bus.mem_wr_addr  = state == SEND ? {addr_q[rd_ptr], beat, 2'b00} : '0;
    assign bus.mem_wr_data  = state == SEND ? data_q[rd_ptr][{beat, 5'd0} +: 32] : '0;

    // pointers and occupancy; full/empty decode only from the registered count
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end

    // line storage, written only on an accepted push
    always_ff @(posedge clk)
        if (push) begin
            addr_q[wr_ptr] <= bus.dc_evict_addr[31:4];
            data_q[wr_ptr] <= bus.dc_evict_data;
        end

    // drain state and beat registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end

    // start a burst one cycle after lines appear, advance on ack, chain bursts while lines remain
    always_comb begin
        state_n = state;
        beat_n  = beat;
        if (state == IDLE) begin
            state_n = count != '0 ? SEND : IDLE;
            beat_n  = '0;
        end else if (bus.mem_wr_ack) begin
            beat_n = beat + 2'd1;
            if (pop) state_n = (count > (PTR_W+1)'(1) || push) ? SEND : IDLE;
        end
    end

    // scan occupied slots oldest to youngest so a later match overrides an earlier one
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.miss_hit = 1'b0;
`ifdef WB_FWD_EN
        bus.fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((PTR_W+1)'(k) < count && addr_q[idx] == bus.miss_addr[31:4]) begin
                bus.miss_hit = 1'b1;
`ifdef WB_FWD_EN
                bus.fwd_data = data_q[idx];
`endif
            end
        end
    end
endmodule

// File: tb/tb_dc_wb_buffer.sv
// tb_dc_wb_buffer: randomized bench for dc_wb_buffer against a line-queue reference model
module tb_dc_wb_buffer;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dc_wb_buffer_if bus ();
    dc_wb_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // reference model: pending lines in arrival order, words already written of the oldest,
    // and whether lines were pending last cycle (the drain engine needs one cycle to notice)
    logic [27:0]  q_addr [$];
    logic [127:0] q_data [$];
    int           words_done = 0;
    bit           prev_pending = 0;

    function automatic logic [31:0] rand_miss();
        if (q_addr.size() != 0 && $urandom_range(0, 1) == 1)
            return {q_addr[$urandom_range(0, q_addr.size() - 1)], 4'($urandom)};
        return $urandom;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        q_addr.delete();
        q_data.delete();
        words_done = 0;
        prev_pending = 0;
    endtask

    // one clock cycle: drive, check against the model, advance the model, step to posedge+1
    task automatic tick(input bit ev, input logic [31:0] ea, input logic [127:0] ed,
                        input bit ack, input logic [31:0] ma);
        bit           req_e, hit_e, push;
        logic [127:0] fwd_e;
        logic [31:0]  addr_e, data_e;
        bus.dc_evict      = ev;
        bus.dc_evict_addr = ea;
        bus.dc_evict_data = ed;
        bus.mem_wr_ack    = ack;
        bus.miss_addr     = ma;
        #2;
        req_e = q_addr.size() != 0 && prev_pending;
        hit_e = 0;
        fwd_e = '0;
        foreach (q_addr[i])
            if (q_addr[i] == ma[31:4]) begin
                hit_e = 1;
                fwd_e = q_data[i];
            end
        tests++;
        if (bus.wb_full !== (q_addr.size() == DEPTH)) begin
            fails++;
            $display("FAIL wb_full t=%0t got %b exp %b", $time, bus.wb_full, q_addr.size() == DEPTH);
        end
        tests++;
        if (bus.wb_empty !== (q_addr.size() == 0)) begin
            fails++;
            $display("FAIL wb_empty t=%0t got %b exp %b", $time, bus.wb_empty, q_addr.size() == 0);
        end
        tests++;
        if (bus.mem_wr_req !== req_e) begin
            fails++;
            $display("FAIL mem_wr_req t=%0t got %b exp %b", $time, bus.mem_wr_req, req_e);
        end
        tests++;
        if (bus.miss_hit !== hit_e) begin
            fails++;
            $display("FAIL miss_hit t=%0t addr %h got %b exp %b", $time, ma, bus.miss_hit, hit_e);
        end
`ifdef WB_FWD_EN
        tests++;
        if (bus.fwd_data !== fwd_e) begin
            fails++;
            $display("FAIL fwd_data t=%0t got %h exp %h", $time, bus.fwd_data, fwd_e);
        end
`endif
        if (req_e) begin
            addr_e = {q_addr[0], 2'(words_done), 2'b00};
            data_e = q_data[0][32*words_done +: 32];
            tests++;
            if ({bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_last} !== {addr_e, data_e, words_done == 3}) begin
                fails++;
                $display("FAIL beat t=%0t got %h/%h/%b exp %h/%h/%b", $time, bus.mem_wr_addr,
                         bus.mem_wr_data, bus.mem_wr_last, addr_e, data_e, words_done == 3);
            end
        end
        push = ev && q_addr.size() < DEPTH;
        prev_pending = q_addr.size() != 0;
        if (req_e && ack) begin
            if (words_done == 3) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                words_done = 0;
            end else words_done++;
        end
        if (push) begin
            q_addr.push_back(ea[31:4]);
            q_data.push_back(ed);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) tick(0, $urandom, rand_line(), ack, rand_miss());
    endtask

    task automatic test_reset();
        bus.dc_evict = 0;
        bus.dc_evict_addr = '0;
        bus.dc_evict_data = '0;
        bus.mem_wr_ack = 0;
        bus.miss_addr = 32'h0000_1230;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.wb_full, bus.wb_empty, bus.mem_wr_req, bus.mem_wr_last, bus.miss_hit} !== 5'b01000) begin
            fails++;
            $display("FAIL reset_flags got %b exp 01000", {bus.wb_full, bus.wb_empty, bus.mem_wr_req,
                     bus.mem_wr_last, bus.miss_hit});
        end
        tests++;
        if ({bus.mem_wr_addr, bus.mem_wr_data} !== 64'h0) begin
            fails++;
            $display("FAIL reset_outs got %h/%h exp 0/0", bus.mem_wr_addr, bus.mem_wr_data);
        end
        rst = 1'b0;
        model_clear();
        idle(2, 0);
    endtask

    task automatic test_single_burst();
        tick(1, 32'h0000_1230, rand_line(), 1, rand_miss());
        idle(7, 1);
    endtask

    task automatic test_back_to_back();
        tick(1, 32'h0000_2000, rand_line(), 0, rand_miss());
        tick(1, 32'h0000_3010, rand_line(), 0, rand_miss());
        tick(1, 32'h0000_4020, rand_line(), 0, rand_miss());
        idle(2, 0);
        idle(12, 1);
    endtask

    task automatic test_ack_stall();
        tick(1, 32'h0000_5a50, rand_line(), 0, rand_miss());
        idle(1, 0);
        idle(1, 1);
        idle(3, 0);
        idle(6, 1);
    endtask

    task automatic test_miss_hit();
        tick(1, 32'h0000_1230, rand_line(), 0, 32'h0000_1230);
        tick(0, '0, '0, 0, 32'h0000_123C);
        tick(0, '0, '0, 0, 32'h0000_1240);
        tick(0, '0, '0, 1, 32'h0000_1234);
        tick(0, '0, '0, 1, 32'h0000_123C);
        tick(0, '0, '0, 1, 32'h0000_1238);
        tick(0, '0, '0, 1, 32'h0000_123C);
        tick(0, '0, '0, 1, 32'h0000_123C);
        tick(0, '0, '0, 0, 32'h0000_1230);
    endtask

    task automatic test_reset_mid_burst();
        tick(1, 32'h0000_6000, rand_line(), 0, rand_miss());
        tick(1, 32'h0000_7000, rand_line(), 0, rand_miss());
        idle(1, 1);
        idle(2, 1);
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.mem_wr_req, bus.wb_empty, bus.wb_full} !== 3'b010) begin
            fails++;
            $display("FAIL reset_mid_burst req/empty/full got %b exp 010",
                     {bus.mem_wr_req, bus.wb_empty, bus.wb_full});
        end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2, 1);
    endtask

    task automatic test_full_last_ack();
        tick(1, 32'h0000_8000, rand_line(), 0, rand_miss());
        tick(1, 32'h0000_9000, rand_line(), 0, rand_miss());
        idle(1, 1);
        idle(3, 1);
        tick(1, 32'h0000_A000, rand_line(), 1, 32'h0000_A000);
        tick(0, '0, '0, 0, 32'h0000_A000);
        idle(6, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 2) == 0, $urandom, rand_line(), $urandom_range(0, 1) == 1, rand_miss());
        idle(12, 1);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_ack_stall();
        test_miss_hit();
        test_reset_mid_burst();
        test_full_last_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
